serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor; the multi-bit, multi-cycle successor to the team's one-bit full adder.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Processes DIGIT bits per clock through a DIGIT-stage full-adder ripple with a registered carry between digits.
- Returns sum, carry-out and signed overflow through a second valid/ready handshake. Serves area-constrained datapaths where several cycles per add is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- DIGIT, 1, bits processed per cycle. Must divide WIDTH exactly; otherwise elaboration fails.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = a+b+cin; 1 = a-b-cin
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low; rst_n low immediately forces the reset state.
  - Reset state: IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, digit counter=0, carry reg=0, operand shift regs=0.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==RUN).
  - IDLE: on in_valid&&in_ready at an edge:
    - capture a into the A shift reg; capture (sub ? ~b : b) into the B shift reg.
    - carry reg <= cin ^ sub, so sub computes a + ~b + !cin = a - b - cin.
    - counter <= 0; go to RUN.
  - RUN: each edge adds the low DIGIT bits of A, B and the carry reg through DIGIT chained full adders (s = x^y^z, c = majority).
    - The DIGIT result bits shift into sum from the MSB end; A and B shift right by DIGIT.
    - Carry reg <= digit carry-out; counter++.
    - On the edge where counter == WIDTH/DIGIT-1, also:
      - cout <= final carry;
      - ovf <= carry into MSB XOR carry out of MSB;
      - go to DONE.
  - DONE: sum/cout/ovf held stable while out_valid=1 and out_ready=0; in_valid ignored. On an edge with out_ready=1, go to IDLE. sum/cout/ovf keep their value until the next accept.
- Timing and throughput:
  - Latency: out_valid rises exactly N=WIDTH/DIGIT edges after the accept edge.
  - Minimum issue interval: N+2 cycles.
- Widths:
  - Counter width max(1, clog2(N)).
  - DIGIT==WIDTH is legal: RUN lasts one cycle.
  - All arithmetic is modulo 2^WIDTH; no saturation.
- Boundary conditions:
  - in_valid while not IDLE: not accepted, operands unchanged.
  - out_ready high in IDLE/RUN: no effect.
  - rst_n asserted mid-RUN or mid-DONE: pending result discarded, all outputs to reset values. The first edge after release can accept.
  - a, b, cin and sub are sampled only on the accept edge; later changes have no effect.

Test Plan:
- WIDTH=8, DIGIT=1, a=8'h3C, b=8'h5A, cin=0, sub=0, out_ready=1 -> out_valid exactly 8 cycles after accept, sum=8'h96, cout=0, ovf=1.
- Add a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
- Subtract with sub=1, cin=0:
  - a=8'h10, b=8'h20 -> sum=8'hF0, cout=0, ovf=0.
  - a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> sum/cout/ovf constant, in_ready=0, no capture. Raise out_ready -> IDLE next cycle, then new op accepted.
- Reset mid-RUN after 3 digits -> out_valid=0, sum=0, in_ready=1 immediately. Next op a=8'h01, b=8'h01 -> sum=8'h02 after 8 cycles.
- WIDTH=16, DIGIT=4, a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> latency 4 cycles, sum=16'h0000, cout=1, ovf=0. DIGIT=16 gives the same result with latency 1.

Source files
------------

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per clock through a chained
// full-adder slice with a registered carry, behind valid/ready handshakes on both sides.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

  logic [DIGIT-1:0] dsum_c;
  logic             dcarry_c, dcarry_msb_c;

  // One digit of ripple; dcarry_msb_c ends as the carry into the slice's top bit.
  always_comb begin : digit_adder
    logic c;
    c            = carry_q;
    dsum_c       = '0;
    dcarry_msb_c = carry_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dcarry_msb_c = c;
      dsum_c[i]    = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (a_q[i] & c) | (b_q[i] & c);
    end
    dcarry_c = c;
  end

  always_comb begin : next_state
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // Result digits enter at the MSB end so the LSB digit lands at bit 0 after N steps.
        sum_d   = WIDTH'({dsum_c, sum_q} >> DIGIT);
        carry_d = dcarry_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = dcarry_c;
          ovf_d   = dcarry_c ^ dcarry_msb_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8-bit serial instance plus 16-bit instances
// with 4-bit and full-width digits.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 0, ir8, ov8, ordy8 = 0, cin8 = 0, sub8 = 0, co8, of8, bz8;
  logic [7:0] a8 = '0, b8 = '0, s8;

  logic        iv16 = 0, ordy16 = 0, cin16 = 0, sub16 = 0;
  logic [15:0] a16 = '0, b16 = '0, s16a, s16b;
  logic        ir16a, ov16a, co16a, of16a, bz16a;
  logic        ir16b, ov16b, co16b, of16b, bz16b;

  int n_checks = 0;
  int n_fail   = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .sum(s8),
    .cout(co8), .ovf(of8), .busy(bz8));

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16a), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16a), .out_ready(ordy16), .sum(s16a),
    .cout(co16a), .ovf(of16a), .busy(bz16a));

  serial_addsub #(.WIDTH(16), .DIGIT(16)) u_dut16d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16b), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16b), .out_ready(ordy16), .sum(s16b),
    .cout(co16b), .ovf(of16b), .busy(bz16b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one 8-bit op, scrambles the inputs afterwards, returns result and latency.
  task automatic run_op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                         input logic si, output logic [7:0] so, output logic co,
                         output logic ovo, output int lat);
    a8 = ai; b8 = bi; cin8 = ci; sub8 = si; iv8 = 1'b1;
    tick();
    iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = ~ci; sub8 = ~si;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ov8) begin lat = c; break; end
    end
    so = s8; co = co8; ovo = of8;
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({ir8, ov8, bz8, s8, co8, of8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset8: ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 0 00 0 0",
               ir8, ov8, bz8, s8, co8, of8);
    end
    n_checks++;
    if ({ir16a, ov16a, bz16a, s16a, ir16b, ov16b, s16b} !== {3'b100, 16'h0, 2'b10, 16'h0}) begin
      n_fail++;
      $display("FAIL reset16: ir=%b/%b ov=%b/%b sum=%h/%h, want ir=1 ov=0 sum=0",
               ir16a, ir16b, ov16a, ov16b, s16a, s16b);
    end
    #3 rst_n = 1'b1;
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
    n_checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_out_ready: ov=%b ir=%b, want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_add();
    logic [7:0] s; logic co, ovo; int lat;
    run_op8(8'h3C, 8'h5A, 1'b0, 1'b0, s, co, ovo, lat);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL add_latency: got %0d want 8", lat); end
    n_checks++;
    if ({s, co, ovo} !== {8'h96, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL add_3c_5a: got %h/%b/%b want 96/0/1", s, co, ovo);
    end
    run_op8(8'hFF, 8'h01, 1'b1, 1'b0, s, co, ovo, lat);
    n_checks++;
    if ({s, co, ovo} !== {8'h01, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_ff_01_c1: got %h/%b/%b want 01/1/0", s, co, ovo);
    end
  endtask

  task automatic test_sub();
    logic [7:0] s; logic co, ovo; int lat;
    run_op8(8'h10, 8'h20, 1'b0, 1'b1, s, co, ovo, lat);
    n_checks++;
    if ({s, co, ovo} !== {8'hF0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_10_20: got %h/%b/%b want f0/0/0", s, co, ovo);
    end
    run_op8(8'h80, 8'h01, 1'b0, 1'b1, s, co, ovo, lat);
    n_checks++;
    if ({s, co, ovo} !== {8'h7F, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sub_80_01: got %h/%b/%b want 7f/1/1", s, co, ovo);
    end
    run_op8(8'h05, 8'h03, 1'b1, 1'b1, s, co, ovo, lat);
    n_checks++;
    if ({s, co, ovo} !== {8'h01, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_05_03_b1: got %h/%b/%b want 01/1/0", s, co, ovo);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a8 = 8'h01; b8 = 8'h02; cin8 = 0; sub8 = 0; iv8 = 1'b1;
    tick();
    n_checks++;
    if (bz8 !== 1'b1 || ir8 !== 1'b0) begin
      n_fail++; $display("FAIL run_flags: busy=%b ir=%b want 1 0", bz8, ir8);
    end
    a8 = 8'h77; b8 = 8'h11;
    for (int c = 0; c < 40 && !ov8; c++) tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({ov8, ir8, s8, co8, of8} !== {1'b1, 1'b0, 8'h03, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d: ov=%b ir=%b sum=%h cout=%b ovf=%b want 1 0 03 0 0",
                 c, ov8, ir8, s8, co8, of8);
      end
      tick();
    end
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
    n_checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      n_fail++; $display("FAIL release: ir=%b ov=%b want 1 0", ir8, ov8);
    end
    tick();
    iv8 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ov8) begin lat = c; break; end
    end
    n_checks++;
    if (lat !== 8 || {s8, co8, of8} !== {8'h88, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL next_op: lat=%0d sum=%h cout=%b ovf=%b want 8 88 0 1", lat, s8, co8, of8);
    end
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic co, ovo; int lat;
    a8 = 8'h55; b8 = 8'h0F; cin8 = 0; sub8 = 0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov8, s8, ir8, bz8} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_run: ov=%b sum=%h ir=%b busy=%b want 0 00 1 0", ov8, s8, ir8, bz8);
    end
    #2 rst_n = 1'b1;
    run_op8(8'h01, 8'h01, 1'b0, 1'b0, s, co, ovo, lat);
    n_checks++;
    if (lat !== 8 || {s, co, ovo} !== {8'h02, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL after_reset: lat=%0d got %h/%b/%b want 8 02/0/0", lat, s, co, ovo);
    end
  endtask

  task automatic test_digit16();
    logic [15:0] va [3] = '{16'hFFFF, 16'h7FFF, 16'h0000};
    logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h0001};
    logic        vs [3] = '{1'b0, 1'b0, 1'b1};
    logic [17:0] ve [3] = '{{16'h0000, 2'b10}, {16'h8000, 2'b01}, {16'hFFFF, 2'b00}};
    int la, lb;
    for (int k = 0; k < 3; k++) begin
      a16 = va[k]; b16 = vb[k]; cin16 = 1'b0; sub16 = vs[k]; iv16 = 1'b1;
      tick();
      iv16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321;
      la = -1; lb = -1;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (ov16a && la < 0) la = c;
        if (ov16b && lb < 0) lb = c;
        if (la > 0 && lb > 0) break;
      end
      n_checks++;
      if (la !== 4 || lb !== 1) begin
        n_fail++; $display("FAIL d16_latency_%0d: got %0d/%0d want 4/1", k, la, lb);
      end
      n_checks++;
      if ({s16a, co16a, of16a} !== ve[k] || {s16b, co16b, of16b} !== ve[k]) begin
        n_fail++;
        $display("FAIL d16_result_%0d: got %h/%b/%b and %h/%b/%b want %h/%b/%b", k,
                 s16a, co16a, of16a, s16b, co16b, of16b, ve[k][17:2], ve[k][1], ve[k][0]);
      end
      ordy16 = 1'b1;
      tick();
      ordy16 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_digit16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
